mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning CPU/memory byte-address width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have cpu_rd  input  1  CPU read request, level, held while cpu_enable low.
REQ-005 SHALL have cpu_wr  input  1  CPU write request, level, held while cpu_enable low.
REQ-006 SHALL have cpu_size  input  2  transfer size: 0=8b, 1=16b, 2=32b, 3=48b (instruction fetch).
REQ-007 SHALL have cpu_addr  input  ADDR_W  byte address; any alignment.
REQ-008 SHALL have cpu_wdata  input  48  write data, little-endian, LSBs used.
REQ-009 SHALL have cpu_rdata  output  48  assembled read data, feeds the CPU data_in port.
REQ-010 SHALL have cpu_enable  output  1  CPU clock enable; low stalls the CPU.
REQ-011 SHALL have mem_req  output  1  memory beat request.
REQ-012 SHALL have mem_we  output  1  beat is a write.
REQ-013 SHALL have mem_addr  output  ADDR_W-1  halfword address.
REQ-014 SHALL have mem_be  output  2  byte enables; bit0 = bits 7:0.
REQ-015 SHALL have mem_wdata  output  16  beat write data.
REQ-016 SHALL have mem_ack  input  1  beat complete; mem_rdata valid same cycle.
REQ-017 SHALL have mem_rdata  input  16  beat read data.

Function
REQ-018 SHALL implement states IDLE, BEAT, DONE.
REQ-019 cpu_enable SHALL be combinational: 1 in IDLE with no request, 0 in IDLE with request, 0 in BEAT, 1 in DONE.
REQ-020 In IDLE with cpu_rd|cpu_wr, SHALL latch addr/size/wdata/direction and enter BEAT next cycle.
REQ-021 cpu_rd and cpu_wr both high SHALL be treated as a write.
REQ-022 Byte count n = 1,2,4,6 for size 0..3; beat count = ceil((addr[0]+n)/2), range 1..4.
REQ-023 Beat k SHALL use mem_addr = (addr>>1)+k, wrapping modulo 2^(ADDR_W-1).
REQ-024 mem_be SHALL enable only lanes covered by the transfer: odd start clears bit0 on first beat; odd end clears bit1 on last beat.
REQ-025 Write data SHALL be lane-shifted so byte i of cpu_wdata lands at byte address addr+i.
REQ-026 Read data byte i SHALL come from byte address addr+i; unused cpu_rdata MSBs SHALL be zero (zero-extend, no sign extension).
REQ-027 In BEAT, mem_req/mem_we/mem_addr/mem_be/mem_wdata SHALL be registered, held stable until mem_ack, and mem_req SHALL be 1.
REQ-028 On mem_ack, SHALL capture the beat; if more beats remain, the next beat SHALL be presented the following cycle with mem_req staying high; otherwise mem_req SHALL drop and the state SHALL go to DONE.
REQ-029 mem_ack while mem_req low SHALL be ignored.
REQ-030 DONE SHALL last exactly one cycle with cpu_rdata valid and cpu_enable 1, then go to IDLE; cpu_rdata SHALL hold until the next read completes.
REQ-031 Minimum latency with zero-wait ack: request seen in IDLE cycle 0, beats from cycle 1, DONE at cycle beats+1.
REQ-032 A request present in IDLE on the cycle after DONE SHALL start a new transaction; no request is lost or repeated.

Reset
REQ-033 rst SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, and beat counter=0.
REQ-034 rst mid-transaction SHALL abandon the transaction with no DONE pulse; a late mem_ack after reset SHALL be ignored.

Verification
REQ-035 Read size=2, addr=0x100, ack each cycle, mem 0x100..0x103 = 11 22 33 44 -> 2 beats at halfword 0x80 and 0x81, be=11 each, cpu_rdata=0x000044332211, cpu_enable low 3 cycles.
REQ-036 Read size=3, addr=0x201 -> 4 beats at 0x100..0x103, be=10,11,11,01, rdata = bytes 0x201..0x206 little-endian.
REQ-037 Write size=0, addr=0x7, wdata=0xAB -> 1 beat, mem_addr=0x3, be=10, mem_wdata=0xAB00, mem_we=1.
REQ-038 Read size=1, addr=0x10 with mem_ack delayed 5 cycles -> mem_req and outputs stable 6 cycles, cpu_enable low throughout, one DONE cycle.
REQ-039 rst asserted during beat 2 of a 4-beat read -> mem_req low immediately, no DONE, stray mem_ack ignored, next request runs normally.
REQ-040 Back-to-back: new read held during DONE and in the next IDLE cycle -> exactly one new transaction, none dropped.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side and memory-side signals of mem_bus_ctrl. The master modport is the controller's
// view; slave is the view of the environment that holds the CPU and the memory.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [47:0]       cpu_wdata;
    logic [47:0]       cpu_rdata;
    logic              cpu_enable;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [1:0]        mem_be;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        input  cpu_rd, cpu_wr, cpu_size, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_rdata, cpu_enable, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_size, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_enable, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Splits one CPU access of 1/2/4/6 bytes at any alignment into 16-bit memory beats and
// stalls the CPU through cpu_enable until the last beat has been acknowledged.
module mem_bus_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_bus_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StBeat, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [47:0]       r_wdata;
    logic              r_we;
    logic [1:0]        r_beat;
    logic [1:0]        r_last_beat;
    logic [55:0]       r_rd_wide;
    logic [47:0]       r_cpu_rdata;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-2:0] r_mem_addr;
    logic [1:0]        r_mem_be;
    logic [15:0]       r_mem_wdata;

    logic              w_req;
    logic              w_start;
    logic              w_ack;
    logic              w_last;

    logic [ADDR_W-1:0] w_src_addr;
    logic [1:0]        w_src_size;
    logic [47:0]       w_src_wdata;
    logic [1:0]        w_src_k;
    logic [63:0]       w_src_wide;
    logic [7:0]        w_src_mask;
    logic [ADDR_W-2:0] w_nx_addr;
    logic [1:0]        w_nx_be;
    logic [15:0]       w_nx_wdata;

    logic [15:0]       w_rd_beat;
    logic [55:0]       w_rd_merged;
    logic [47:0]       w_rd_final;

    // Byte-lane mask over the halfword-aligned window; bit j is byte (addr & ~1) + j.
    function automatic logic [7:0] f_lane_mask(input logic [1:0] size, input logic a0);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'h3F;
        endcase
        return mask << a0;
    endfunction

    function automatic logic [1:0] f_last_beat(input logic [1:0] size, input logic a0);
        logic [2:0] nbytes;
        logic [2:0] span;
        case (size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd6;
        endcase
        span = {2'b00, a0} + nbytes - 3'd1;
        return span[2:1];
    endfunction

    assign w_req   = bus.cpu_rd | bus.cpu_wr;
    assign w_start = (r_state == StIdle) && w_req;
    assign w_ack   = r_mem_req & bus.mem_ack;
    assign w_last  = (r_beat == r_last_beat);

    // Beat 0 comes straight from the CPU inputs; later beats from the latched request.
    always_comb begin
        if (r_state == StIdle) begin
            w_src_addr  = bus.cpu_addr;
            w_src_size  = bus.cpu_size;
            w_src_wdata = bus.cpu_wdata;
            w_src_k     = 2'd0;
        end else begin
            w_src_addr  = r_addr;
            w_src_size  = r_size;
            w_src_wdata = r_wdata;
            w_src_k     = r_beat + 2'd1;
        end
    end

    always_comb begin
        w_src_wide = w_src_addr[0] ? {8'h00, w_src_wdata, 8'h00} : {16'h0000, w_src_wdata};
        w_src_mask = f_lane_mask(w_src_size, w_src_addr[0]);
        w_nx_be    = w_src_mask[{w_src_k, 1'b0} +: 2];
        w_nx_wdata = w_src_wide[{w_src_k, 4'b0000} +: 16];
        w_nx_addr  = w_src_addr[ADDR_W-1:1] + {{(ADDR_W-3){1'b0}}, w_src_k};
    end

    // Lanes outside the transfer are dropped so unused result bytes stay zero.
    always_comb begin
        w_rd_beat   = {bus.mem_rdata[15:8] & {8{r_mem_be[1]}},
                       bus.mem_rdata[7:0]  & {8{r_mem_be[0]}}};
        w_rd_merged = r_rd_wide | 56'(64'(w_rd_beat) << {r_beat, 4'b0000});
        w_rd_final  = r_addr[0] ? w_rd_merged[55:8] : w_rd_merged[47:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_req) w_state_next = StBeat;
            StBeat:  if (w_ack && w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.cpu_enable = ((r_state == StIdle) && !w_req) || (r_state == StDone);
        bus.cpu_rdata  = r_cpu_rdata;
        bus.mem_req    = r_mem_req;
        bus.mem_we     = r_mem_we;
        bus.mem_addr   = r_mem_addr;
        bus.mem_be     = r_mem_be;
        bus.mem_wdata  = r_mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_rd_wide   <= '0;
            r_cpu_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else if (w_start) begin
            r_addr      <= bus.cpu_addr;
            r_size      <= bus.cpu_size;
            r_wdata     <= bus.cpu_wdata;
            r_we        <= bus.cpu_wr;
            r_beat      <= 2'd0;
            r_last_beat <= f_last_beat(bus.cpu_size, bus.cpu_addr[0]);
            r_rd_wide   <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.cpu_wr;
            r_mem_addr  <= w_nx_addr;
            r_mem_be    <= w_nx_be;
            r_mem_wdata <= w_nx_wdata;
        end else if (w_ack) begin
            if (!r_we) begin
                r_rd_wide <= w_rd_merged;
            end
            if (w_last) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (!r_we) begin
                    r_cpu_rdata <= w_rd_final;
                end
            end else begin
                r_beat      <= r_beat + 2'd1;
                r_mem_addr  <= w_nx_addr;
                r_mem_be    <= w_nx_be;
                r_mem_wdata <= w_nx_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a byte-array memory with programmable ack delay, a beat
// log, and a linear sequence of CPU accesses with hand-computed expectations.
module tb_mem_bus_ctrl;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_bus_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem [1024];
    int          wait_cfg  = 0;
    int          cnt       = 0;
    logic        force_ack = 1'b0;
    int          unstable  = 0;
    logic        was_wait  = 1'b0;
    logic [50:0] saved     = '0;

    logic [30:0] q_addr [$];
    logic [1:0]  q_be   [$];
    logic [15:0] q_wd   [$];
    logic        q_we   [$];
    int          q_hold [$];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always_comb bus.mem_ack = force_ack | (bus.mem_req && (cnt == wait_cfg));
    always_comb bus.mem_rdata = {mem[{bus.mem_addr[8:0], 1'b1}], mem[{bus.mem_addr[8:0], 1'b0}]};

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            q_addr.push_back(bus.mem_addr);
            q_be.push_back(bus.mem_be);
            q_wd.push_back(bus.mem_wdata);
            q_we.push_back(bus.mem_we);
            q_hold.push_back(cnt + 1);
            cnt <= 0;
        end else if (bus.mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    // A beat waiting for ack must keep every bus output unchanged.
    always @(negedge clk) begin
        if (was_wait && bus.mem_req &&
            ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we} !== saved)) begin
            unstable <= unstable + 1;
        end
        was_wait <= bus.mem_req && !bus.mem_ack;
        saved    <= {bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [30:0] addr,
                            input logic [1:0] be, input logic we, input logic chk_wd,
                            input logic [15:0] wd);
        if (idx < q_addr.size()) begin
            chk({tag, "_addr"}, q_addr[idx], addr);
            chk({tag, "_be"}, q_be[idx], be);
            chk({tag, "_we"}, q_we[idx], we);
            if (chk_wd) chk({tag, "_wdata"}, q_wd[idx], wd);
        end else begin
            chk({tag, "_present"}, q_addr.size(), idx + 1);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [47:0] wdata);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_size  = size;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Counts negedges with cpu_enable low; returns once enable is high (the DONE cycle).
    task automatic wait_done(output int stalls);
        stalls = 0;
        #1;
        while (!bus.cpu_enable && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
    endtask

    initial begin
        int st;
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;
        mem[10'h102] = 8'h33;
        mem[10'h103] = 8'h44;
        for (int i = 0; i < 8; i++) mem[10'h200 + i] = 8'h50 + 8'(i);
        mem[10'h010] = 8'hC3;
        mem[10'h011] = 8'h5A;
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_cpu_enable", bus.cpu_enable, 1);
        rst = 1'b0;

        // 32-bit aligned read
        @(negedge clk);
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd2, 32'h100, 48'h0);
        wait_done(st);
        chk("rd32_stalls", st, 3);
        chk("rd32_rdata", bus.cpu_rdata, 48'h0000_4433_2211);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("rd32_beats", q_addr.size() - base, 2);
        chk_beat("rd32_b0", base + 0, 31'h80, 2'b11, 1'b0, 1'b0, 16'h0);
        chk_beat("rd32_b1", base + 1, 31'h81, 2'b11, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        #1 chk("rd32_idle_enable", bus.cpu_enable, 1);

        // 48-bit fetch from an odd address
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd3, 32'h201, 48'h0);
        wait_done(st);
        chk("rd48_stalls", st, 5);
        chk("rd48_rdata", bus.cpu_rdata, 48'h5655_5453_5251);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("rd48_beats", q_addr.size() - base, 4);
        chk_beat("rd48_b0", base + 0, 31'h100, 2'b10, 1'b0, 1'b0, 16'h0);
        chk_beat("rd48_b1", base + 1, 31'h101, 2'b11, 1'b0, 1'b0, 16'h0);
        chk_beat("rd48_b2", base + 2, 31'h102, 2'b11, 1'b0, 1'b0, 16'h0);
        chk_beat("rd48_b3", base + 3, 31'h103, 2'b01, 1'b0, 1'b0, 16'h0);

        // byte write to an odd address; last read data must hold
        @(negedge clk);
        base = q_addr.size();
        issue(1'b0, 1'b1, 2'd0, 32'h7, 48'hAB);
        wait_done(st);
        chk("wr8_stalls", st, 2);
        chk("wr8_rdata_hold", bus.cpu_rdata, 48'h5655_5453_5251);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("wr8_beats", q_addr.size() - base, 1);
        chk_beat("wr8_b0", base, 31'h3, 2'b10, 1'b1, 1'b1, 16'hAB00);

        // rd and wr together count as a write
        @(negedge clk);
        base = q_addr.size();
        issue(1'b1, 1'b1, 2'd1, 32'h20, 48'h1234);
        wait_done(st);
        chk("rdwr_stalls", st, 2);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("rdwr_beats", q_addr.size() - base, 1);
        chk_beat("rdwr_b0", base, 31'h10, 2'b11, 1'b1, 1'b1, 16'h1234);

        // halfword read with a 5-cycle ack delay
        @(negedge clk);
        wait_cfg = 5;
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd1, 32'h10, 48'h0);
        wait_done(st);
        chk("slow_stalls", st, 7);
        chk("slow_rdata", bus.cpu_rdata, 48'h5AC3);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        wait_cfg = 0;
        chk("slow_beats", q_addr.size() - base, 1);
        chk_beat("slow_b0", base, 31'h8, 2'b11, 1'b0, 1'b0, 16'h0);
        if (q_hold.size() > base) chk("slow_hold", q_hold[base], 6);
        else chk("slow_hold_present", q_hold.size(), base + 1);
        chk("slow_unstable", unstable, 0);
        @(negedge clk);
        #1 chk("slow_one_done", bus.cpu_enable, 1);

        // reset during beat 1 of a 4-beat read, then a stray ack
        @(negedge clk);
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd3, 32'h201, 48'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("rstmid_mem_req", bus.mem_req, 0);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("rstmid_rdata_clr", bus.cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        #1 chk("rstmid_req_after", bus.mem_req, 0);
        chk("rstmid_enable", bus.cpu_enable, 1);
        chk("rstmid_beats", q_addr.size() - base, 1);
        chk("rstmid_rdata_after", bus.cpu_rdata, 0);

        @(negedge clk);
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd2, 32'h100, 48'h0);
        wait_done(st);
        chk("rec_stalls", st, 3);
        chk("rec_rdata", bus.cpu_rdata, 48'h4433_2211);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk("rec_beats", q_addr.size() - base, 2);

        // back-to-back: next read already held during DONE
        @(negedge clk);
        base = q_addr.size();
        issue(1'b1, 1'b0, 2'd0, 32'h103, 48'h0);
        wait_done(st);
        chk("b2b_a_stalls", st, 2);
        chk("b2b_a_rdata", bus.cpu_rdata, 48'h44);
        issue(1'b1, 1'b0, 2'd1, 32'h101, 48'h0);
        @(negedge clk);
        wait_done(st);
        chk("b2b_b_stalls", st, 3);
        chk("b2b_b_rdata", bus.cpu_rdata, 48'h3322);
        issue(1'b0, 1'b0, 2'd0, 32'h0, 48'h0);
        chk_beat("b2b_a_b0", base + 0, 31'h81, 2'b10, 1'b0, 1'b0, 16'h0);
        chk_beat("b2b_b_b0", base + 1, 31'h80, 2'b10, 1'b0, 1'b0, 16'h0);
        chk_beat("b2b_b_b1", base + 2, 31'h81, 2'b01, 1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("b2b_beats", q_addr.size() - base, 3);
        chk("b2b_idle_enable", bus.cpu_enable, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
